// File: rtl/ram_ctrl_pkg.sv
// Shared types for the MFA/MOC byte-addressable RAM controller.
// SIZE encodings, FSM states and the default BUSY wait length.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int WAIT_CYCLES_DEF = 1;

endpackage

// File: rtl/ram256x8_core.sv
// 256x8 storage, four big-endian byte lanes per word row.
// Lane 3 (wdata[31:24]) is the lowest byte address of the row.
module ram256x8_core (
  input  logic        CLK,
  input  logic [5:0]  wa,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge CLK) begin
    for (int j = 0; j < 4; j++) begin
      if (we[j]) begin
        mem[{wa, 2'(3 - j)}] <= wdata[8*j +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < 4; j++) begin
      rdata[8*j +: 8] = mem[{wa, 2'(3 - j)}];
    end
  end

endmodule

// File: rtl/ram_mfa_ctrl.sv
// MFA/MOC handshake RAM controller: IDLE -> BUSY -> DONE.
// RAM_ALIGN_CHECK_EN enables alignment/SIZE error reporting on ERR.
module ram_mfa_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        MOC,
  output logic        ERR
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        moc_n, err_n;
  logic [31:0] dout_n;
  logic        accept;

  logic        rw_q;
  size_e       sz_q;
  logic [7:0]  a_q;
  logic [31:0] d_q;

  logic        bad;
  size_e       esz;
  logic [7:0]  ea;
  logic [1:0]  lane;
  logic [3:0]  we_l, we;
  logic [31:0] wd, rdata, rd;

  always_comb begin
    esz = sz_q;
    ea  = a_q;
`ifdef RAM_ALIGN_CHECK_EN
    bad = (sz_q == SZ_HALF && a_q[0])
       || (sz_q == SZ_WORD && a_q[1:0] != 2'b00)
       || (sz_q == SZ_RSVD);
`else
    bad = 1'b0;
    if (sz_q == SZ_RSVD) esz = SZ_WORD;
    if (esz == SZ_HALF) ea[0] = 1'b0;
    if (esz == SZ_WORD) ea[1:0] = 2'b00;
`endif
  end

  // byte offset k sits on lane 3-k
  assign lane = ~ea[1:0];

  always_comb begin
    we_l = 4'b1111;
    wd   = d_q;
    rd   = rdata;
    unique case (1'b1)
      esz == SZ_BYTE: begin
        we_l = 4'b1000 >> ea[1:0];
        wd   = {4{d_q[7:0]}};
        rd   = {24'h0, rdata[{lane, 3'b000} +: 8]};
      end
      esz == SZ_HALF: begin
        we_l = ea[1] ? 4'b0011 : 4'b1100;
        wd   = {2{d_q[15:0]}};
        rd   = {16'h0, ea[1] ? rdata[15:0] : rdata[31:16]};
      end
      default: begin
        we_l = 4'b1111;
        wd   = d_q;
        rd   = rdata;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    moc_n   = MOC;
    err_n   = ERR;
    dout_n  = DOUT;
    accept  = 1'b0;
    we      = 4'b0000;
    unique case (state)
      IDLE: begin
        if (MFA) begin
          accept  = 1'b1;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!MFA) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          state_n = DONE;
          moc_n   = 1'b1;
          err_n   = bad;
          if (bad) dout_n = '0;
          else if (rw_q) dout_n = rd;
          else we = we_l;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        if (!MFA) begin
          state_n = IDLE;
          moc_n   = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
      cnt   <= '0;
      MOC   <= 1'b0;
      ERR   <= 1'b0;
      DOUT  <= '0;
      rw_q  <= 1'b0;
      sz_q  <= SZ_BYTE;
      a_q   <= '0;
      d_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      MOC   <= moc_n;
      ERR   <= err_n;
      DOUT  <= dout_n;
      if (accept) begin
        rw_q <= RW;
        sz_q <= size_e'(SIZE);
        a_q  <= ADDR;
        d_q  <= DIN;
      end
    end
  end

  ram256x8_core u_core (
    .CLK   (CLK),
    .wa    (ea[7:2]),
    .we    (we),
    .wdata (wd),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ram_mfa_ctrl.sv
// Directed bench for ram_mfa_ctrl (WAIT_CYCLES 1 and 3 instances).
// Expectations follow RAM_ALIGN_CHECK_EN when it is defined.
module tb_ram_mfa_ctrl;
  import ram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        mfa, rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] din, dout;
  logic        moc, err;
  logic        mfa3, rw3;
  logic [1:0]  size3;
  logic [7:0]  addr3;
  logic [31:0] din3, dout3;
  logic        moc3, err3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_mfa_ctrl #(.WAIT_CYCLES(1)) dut (
    .CLK(clk), .CLR(clr), .MFA(mfa), .RW(rw), .SIZE(size),
    .ADDR(addr), .DIN(din), .DOUT(dout), .MOC(moc), .ERR(err)
  );

  ram_mfa_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .CLK(clk), .CLR(clr), .MFA(mfa3), .RW(rw3), .SIZE(size3),
    .ADDR(addr3), .DIN(din3), .DOUT(dout3), .MOC(moc3), .ERR(err3)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] edout;
    logic        eerr;
    int          hold;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input bit u3, input logic rw_i,
                        input logic [1:0] sz_i, input logic [7:0] a_i,
                        input logic [31:0] d_i, input int hold,
                        input string nm, output logic [31:0] dout_o,
                        output logic err_o);
    int   n;
    logic m;
    @(negedge clk);
    if (u3) begin
      mfa3 = 1'b1; rw3 = rw_i; size3 = sz_i; addr3 = a_i; din3 = d_i;
    end else begin
      mfa = 1'b1; rw = rw_i; size = sz_i; addr = a_i; din = d_i;
    end
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      m = u3 ? moc3 : moc;
    end while (!m && n < 20);
    chk({nm, " latency"}, n, u3 ? 4 : 2);
    dout_o = u3 ? dout3 : dout;
    err_o  = u3 ? err3 : err;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, " moc held"}, u3 ? moc3 : moc, 1);
    end
    if (u3) mfa3 = 1'b0;
    else mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " moc clear"}, u3 ? moc3 : moc, 0);
    chk({nm, " err clear"}, u3 ? err3 : err, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        seen;
    int          n;

    tv.push_back('{1, SZ_WORD, 8'h80, 32'h0, 32'h87654321, 0, 0});
    tv.push_back('{0, SZ_WORD, 8'h10, 32'hA1B2C3D4, 32'h87654321, 0, 0});
    tv.push_back('{1, SZ_BYTE, 8'h10, 32'h0, 32'h000000A1, 0, 0});
    tv.push_back('{1, SZ_BYTE, 8'h11, 32'h0, 32'h000000B2, 0, 0});
    tv.push_back('{1, SZ_BYTE, 8'h12, 32'h0, 32'h000000C3, 0, 0});
    tv.push_back('{1, SZ_BYTE, 8'h13, 32'h0, 32'h000000D4, 0, 0});
    tv.push_back('{1, SZ_HALF, 8'h12, 32'h0, 32'h0000C3D4, 0, 3});
    tv.push_back('{1, SZ_HALF, 8'h10, 32'h0, 32'h0000A1B2, 0, 0});
    tv.push_back('{0, SZ_HALF, 8'h22, 32'hDEADBEEF, 32'h0000A1B2, 0, 0});
    tv.push_back('{0, SZ_BYTE, 8'h21, 32'h12345677, 32'h0000A1B2, 0, 0});
    tv.push_back('{0, SZ_BYTE, 8'h20, 32'h00000055, 32'h0000A1B2, 0, 0});
    tv.push_back('{1, SZ_WORD, 8'h20, 32'h0, 32'h5577BEEF, 0, 0});
    tv.push_back('{0, SZ_WORD, 8'hFC, 32'h01020304, 32'h5577BEEF, 0, 0});
    tv.push_back('{1, SZ_WORD, 8'hFC, 32'h0, 32'h01020304, 0, 0});
    tv.push_back('{1, SZ_BYTE, 8'hFF, 32'h0, 32'h00000004, 0, 0});
`ifdef RAM_ALIGN_CHECK_EN
    tv.push_back('{1, SZ_HALF, 8'h11, 32'h0, 32'h0, 1, 0});
    tv.push_back('{0, SZ_WORD, 8'h11, 32'h11223344, 32'h0, 1, 0});
    tv.push_back('{1, SZ_WORD, 8'h10, 32'h0, 32'hA1B2C3D4, 0, 0});
    tv.push_back('{0, SZ_BYTE, 8'h13, 32'h000000EE, 32'hA1B2C3D4, 0, 0});
    tv.push_back('{1, SZ_WORD, 8'h10, 32'h0, 32'hA1B2C3EE, 0, 0});
    tv.push_back('{1, SZ_RSVD, 8'h20, 32'h0, 32'h0, 1, 0});
`else
    tv.push_back('{1, SZ_HALF, 8'h11, 32'h0, 32'h0000A1B2, 0, 0});
    tv.push_back('{0, SZ_WORD, 8'h11, 32'h11223344, 32'h0000A1B2, 0, 0});
    tv.push_back('{1, SZ_WORD, 8'h10, 32'h0, 32'h11223344, 0, 0});
    tv.push_back('{0, SZ_BYTE, 8'h13, 32'h000000EE, 32'h11223344, 0, 0});
    tv.push_back('{1, SZ_WORD, 8'h10, 32'h0, 32'h112233EE, 0, 0});
    tv.push_back('{1, SZ_RSVD, 8'h20, 32'h0, 32'h5577BEEF, 0, 0});
`endif
    tv.push_back('{1, SZ_WORD, 8'h80, 32'h0, 32'h87654321, 0, 0});

    // reset with a write request already pending
    clr = 1'b0;
    mfa = 1'b1; rw = 1'b0; size = SZ_WORD;
    addr = 8'h80; din = 32'h87654321;
    mfa3 = 1'b0; rw3 = 1'b0; size3 = SZ_BYTE;
    addr3 = 8'h0; din3 = 32'h0;
    #12;
    chk("reset moc", moc, 0);
    chk("reset err", err, 0);
    chk("reset dout", dout, 0);
    chk("reset moc3", moc3, 0);
    @(negedge clk);
    clr = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!moc && n < 20);
    chk("post-reset accept latency", n, 2);
    mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset moc clear", moc, 0);

    foreach (tv[i]) begin
      access(0, tv[i].rw, tv[i].sz, tv[i].a, tv[i].d, tv[i].hold,
             $sformatf("vec%0d", i), d, e);
      chk($sformatf("vec%0d dout", i), d, tv[i].edout);
      chk($sformatf("vec%0d err", i), e, tv[i].eerr);
    end

    // CLR pulse during BUSY of a write
    access(0, 0, SZ_WORD, 8'h40, 32'h11111111, 0, "pre-clr wr", d, e);
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = SZ_WORD;
    addr = 8'h40; din = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    clr = 1'b0;
    mfa = 1'b0;
    #1;
    chk("clr moc", moc, 0);
    chk("clr err", err, 0);
    chk("clr dout", dout, 0);
    #1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-clr moc", moc, 0);
    access(0, 1, SZ_WORD, 8'h40, 32'h0, 0, "post-clr rd", d, e);
    chk("post-clr rd dout", d, 32'h11111111);

    // WAIT_CYCLES = 3: abort after two BUSY cycles
    access(1, 0, SZ_BYTE, 8'h20, 32'h0000005A, 0, "w3 wr", d, e);
    access(1, 1, SZ_BYTE, 8'h20, 32'h0, 0, "w3 rd", d, e);
    chk("w3 rd dout", d, 32'h0000005A);
    @(negedge clk);
    mfa3 = 1'b1; rw3 = 1'b0; size3 = SZ_BYTE;
    addr3 = 8'h20; din3 = 32'h000000FF;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      seen |= moc3;
    end
    mfa3 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      seen |= moc3;
    end
    chk("abort moc never", seen, 0);
    chk("abort dout held", dout3, 32'h0000005A);
    access(1, 1, SZ_BYTE, 8'h20, 32'h0, 0, "abort rd", d, e);
    chk("abort rd dout", d, 32'h0000005A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
